// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter sampler: default widths, FSM states
// and modular subtraction.
package ripple_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned EXT_W_DEF = 16;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    // (a - b) mod 2^w; callers truncate the result to w bits.
    function automatic logic [31:0] mod_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ripple_stab_filter.sv
// Synchronises the raw ripple counter bits into clk and pulses accept once the
// synced value has stayed unchanged for STABLE_CYCLES consecutive samples.
module ripple_stab_filter #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] s,
    output logic             accept
);

    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    logic [CNT_W-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q;
    logic [CNT_W-1:0]       prev_q;
    logic                   prev_vld;
    logic [SW-1:0]          stab;
    logic                   same;

    assign s = sync_q[SYNC_STAGES-1];

    // Valid bits track the post-reset fill so the cleared flops are never
    // taken as a real sample (which would otherwise become a bogus baseline).
    always_comb begin
        same   = vld_q[SYNC_STAGES-1] && prev_vld && (s == prev_q);
        accept = same && (stab == SW'(STABLE_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            vld_q    <= '0;
            prev_q   <= '0;
            prev_vld <= 1'b0;
            stab     <= '0;
        end else begin
            sync_q[0] <= cnt_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q   <= s;
            prev_vld <= vld_q[SYNC_STAGES-1];
            if (!same || accept) stab <= '0;
            else                 stab <= stab + SW'(1);
        end
    end

endmodule

// File: rtl/ripple_sync_sampler.sv
// Samples an asynchronous ripple counter, converts settled values into wrap-aware
// deltas and hands them out over valid/ready. Optional macro RIPPLE_SYNC_OVF_CLR_EN
// adds an ovf_clr input to clear the sticky overflow flag.
module ripple_sync_sampler
    import ripple_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned EXT_W         = EXT_W_DEF,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             out_ready,
`ifdef RIPPLE_SYNC_OVF_CLR_EN
    input  logic             ovf_clr,
`endif
    output logic             out_valid,
    output logic [CNT_W-1:0] out_delta,
    output logic [EXT_W-1:0] cnt_ext,
    output logic             overflow
);

    logic [CNT_W-1:0] s;
    logic             accept;

    ripple_stab_filter #(
        .CNT_W        (CNT_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk   (clk),
        .reset (reset),
        .cnt_in(cnt_in),
        .s     (s),
        .accept(accept)
    );

    state_t           state, state_n;
    logic [CNT_W-1:0] baseline, baseline_n, pending, pending_n;
    logic [CNT_W-1:0] d, pend_sum, out_delta_n;
    logic [CNT_W:0]   sum;
    logic             sat, out_valid_n, overflow_n;
    logic [EXT_W-1:0] cnt_ext_n;

    always_comb begin
        state_n     = state;
        baseline_n  = baseline;
        cnt_ext_n   = cnt_ext;
        pend_sum    = pending;
        pending_n   = pending;
        sat         = 1'b0;
        out_valid_n = out_valid;
        out_delta_n = out_delta;
        overflow_n  = overflow;
        d           = CNT_W'(mod_sub(32'(s), 32'(baseline), CNT_W));
        sum         = {1'b0, pending} + {1'b0, d};

        if (accept) begin
            case (state)
                ST_INIT: begin
                    baseline_n = s;
                    state_n    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (d != '0) begin
                        baseline_n = s;
                        cnt_ext_n  = cnt_ext + EXT_W'(d);
                        if (sum[CNT_W]) begin
                            pend_sum = '1;
                            sat      = 1'b1;
                        end else begin
                            pend_sum = sum[CNT_W-1:0];
                        end
                    end
                end
            endcase
        end

        // The accept's delta is folded into pending before any transfer.
        if (!out_valid || out_ready) begin
            pending_n   = '0;
            out_valid_n = (pend_sum != '0);
            if (pend_sum != '0) out_delta_n = pend_sum;
        end else begin
            pending_n = pend_sum;
        end

`ifdef RIPPLE_SYNC_OVF_CLR_EN
        if (ovf_clr) overflow_n = 1'b0;
`endif
        if (sat) overflow_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            baseline  <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_delta <= '0;
            cnt_ext   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            baseline  <= baseline_n;
            pending   <= pending_n;
            out_valid <= out_valid_n;
            out_delta <= out_delta_n;
            cnt_ext   <= cnt_ext_n;
            overflow  <= overflow_n;
        end
    end

endmodule

// File: tb/tb_ripple_sync_sampler.sv
// Directed bench for ripple_sync_sampler with hand-computed expectations.
module tb_ripple_sync_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_delta;
    logic [15:0] cnt_ext;
    logic        overflow;
`ifdef RIPPLE_SYNC_OVF_CLR_EN
    logic        ovf_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic seen_v;

    always #5 clk = ~clk;

    ripple_sync_sampler #(
        .CNT_W        (4),
        .EXT_W        (16),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt_in   (cnt_in),
        .out_ready(out_ready),
`ifdef RIPPLE_SYNC_OVF_CLR_EN
        .ovf_clr  (ovf_clr),
`endif
        .out_valid(out_valid),
        .out_delta(out_delta),
        .cnt_ext  (cnt_ext),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input int n);
        @(negedge clk);
        cnt_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        cnt_in    = 4'd5;
        out_ready = 1'b0;
`ifdef RIPPLE_SYNC_OVF_CLR_EN
        ovf_clr   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_delta", 32'(out_delta), 0);
        chk("rst_ext", 32'(cnt_ext), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Held 5 only becomes the baseline
        repeat (10) @(negedge clk);
        chk("base_valid", 32'(out_valid), 0);
        chk("base_ext", 32'(cnt_ext), 0);
        step(4'd7, 4);
        chk("lat_early", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_delta", 32'(out_delta), 2);
        chk("lat_ext", 32'(cnt_ext), 2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_drop", 32'(out_valid), 0);

        // Wrap 14 -> 1
        step(4'd14, 10);
        chk("to14_ext", 32'(cnt_ext), 9);
        chk("to14_idle", 32'(out_valid), 0);
        step(4'd1, 5);
        chk("wrap_valid", 32'(out_valid), 1);
        chk("wrap_delta", 32'(out_delta), 3);
        chk("wrap_ext", 32'(cnt_ext), 12);
        @(negedge clk);
        chk("wrap_drop", 32'(out_valid), 0);

        // Backpressure accumulation
        out_ready = 1'b0;
        step(4'd2, 5);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_delta", 32'(out_delta), 1);
        step(4'd3, 8);
        step(4'd4, 8);
        step(4'd5, 8);
        chk("bp_hold_v", 32'(out_valid), 1);
        chk("bp_hold_d", 32'(out_delta), 1);
        chk("bp_ext", 32'(cnt_ext), 16);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_v", 32'(out_valid), 1);
        chk("bp_next_d", 32'(out_delta), 3);
        @(negedge clk);
        chk("bp_drop", 32'(out_valid), 0);

        // Pending saturation
        out_ready = 1'b0;
        step(4'd6, 8);
        chk("sat_first", 32'(out_delta), 1);
        step(4'd10, 8);
        step(4'd14, 8);
        step(4'd2, 8);
        chk("sat_ovf_pre", 32'(overflow), 0);
        step(4'd6, 8);
        chk("sat_ovf_set", 32'(overflow), 1);
        step(4'd10, 8);
        step(4'd14, 8);
        chk("sat_ext", 32'(cnt_ext), 41);
        chk("sat_hold_d", 32'(out_delta), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("sat_rec_v", 32'(out_valid), 1);
        chk("sat_rec_d", 32'(out_delta), 15);
        @(negedge clk);
        chk("sat_drop", 32'(out_valid), 0);
        chk("sat_sticky", 32'(overflow), 1);
`ifdef RIPPLE_SYNC_OVF_CLR_EN
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
`endif

        // Single-cycle glitch 6 -> 7 -> 6
        step(4'd6, 10);
        chk("gl_base_ext", 32'(cnt_ext), 49);
        seen_v = 1'b0;
        @(negedge clk);
        cnt_in = 4'd7;
        @(negedge clk);
        cnt_in = 4'd6;
        repeat (12) begin
            @(negedge clk);
            seen_v = seen_v | out_valid;
        end
        chk("gl_novalid", 32'(seen_v), 0);
        chk("gl_ext", 32'(cnt_ext), 49);

        // Async reset mid-stall
        out_ready = 1'b0;
        step(4'd9, 8);
        chk("mr_valid", 32'(out_valid), 1);
        chk("mr_ext", 32'(cnt_ext), 52);
        #2 reset = 1'b1;
        #1;
        chk("mr_rst_v", 32'(out_valid), 0);
        chk("mr_rst_ext", 32'(cnt_ext), 0);
        chk("mr_rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mr_base_v", 32'(out_valid), 0);
        chk("mr_base_ext", 32'(cnt_ext), 0);
        step(4'd11, 5);
        chk("mr_post_v", 32'(out_valid), 1);
        chk("mr_post_d", 32'(out_delta), 2);
        chk("mr_post_ext", 32'(cnt_ext), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
